seq_divider: RTL

Iterative restoring divider, the inverse companion to the parallel multiplier. Accepts an N-bit dividend and divisor over a valid/ready handshake and computes quotient and remainder one bit per clock. Results are held until the consumer accepts them. It is the area-cheap division path beside the combinational multiplier, with registered inputs and outputs so it can be timed standalone.

---
 rtl/div_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 25 ++
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 136 +++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Optional signed mode is enabled by SEQ_DIVIDER_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Quotient reported for a zero divisor: all ones at width w (w <= 64).
    function automatic logic [63:0] dbz_quot(input int w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result valid-ready bundle for seq_divider.
// The divider side uses the slave modport.
interface seq_divider_if #(
    parameter int N = 32
);
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div_by_zero;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output a_in, b_in, in_valid, out_ready,
        input  in_ready, q, r, div_by_zero, out_valid
    );

    modport slave (
        input  a_in, b_in, in_valid, out_ready,
        output in_ready, q, r, div_by_zero, out_valid
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// The extra top bit of the trial difference acts as the borrow/sign.
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem_i,
    input  logic         msb_i,
    input  logic [N-1:0] dsr_i,
    output logic [N:0]   rem_o,
    output logic         q_o
);
    logic [N+1:0] wide;
    logic [N+1:0] trial;

    always_comb begin
        wide  = {rem_i, msb_i};
        trial = wide - {2'b00, dsr_i};
        q_o   = ~trial[N+1];
        rem_o = q_o ? trial[N:0] : wide[N:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready I/O.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
    import div_pkg::*;
#(
    parameter  int N  = 32,
    localparam int CW = $clog2(N + 1)
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam logic [N-1:0] QDBZ = N'(dbz_quot(N));

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [N-1:0]   dsr_q, dsr_d;
    logic [N:0]     rem_q, rem_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           dbz_q, dbz_d;
    logic [N:0]     step_rem;
    logic           step_bit;
    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   q_raw, r_raw;
    logic [N-1:0]   q_fin, r_fin;

    div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[N-1]),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

    assign q_raw = {dvd_q[N-2:0], step_bit};
    // A zero divisor runs one dummy step; dvd still holds |a| untouched.
    assign r_raw = dbz_q ? dvd_q : step_rem[N-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic a_neg_q, a_neg_d;
    logic q_neg_q, q_neg_d;

    assign a_mag = bus.a_in[N-1] ? -bus.a_in : bus.a_in;
    assign b_mag = bus.b_in[N-1] ? -bus.b_in : bus.b_in;
    assign q_fin = q_neg_q ? -q_raw : q_raw;
    assign r_fin = a_neg_q ? -r_raw : r_raw;
`else
    assign a_mag = bus.a_in;
    assign b_mag = bus.b_in;
    assign q_fin = q_raw;
    assign r_fin = r_raw;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        a_neg_d = a_neg_q;
        q_neg_d = q_neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvd_d   = a_mag;
                    dsr_d   = b_mag;
                    rem_d   = '0;
                    dbz_d   = (bus.b_in == '0);
                    cnt_d   = dbz_d ? CW'(1) : CW'(N);
                    state_d = CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    a_neg_d = bus.a_in[N-1];
                    q_neg_d = bus.a_in[N-1] ^ bus.b_in[N-1];
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                dvd_d = q_raw;
                rem_d = step_rem;
                if (cnt_q == CW'(1)) begin
                    q_d     = dbz_q ? QDBZ : q_fin;
                    r_d     = r_fin;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            a_neg_q <= a_neg_d;
            q_neg_q <= q_neg_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;
endmodule
